// File: rtl/override_scheduler.sv
// Round-robin owner of a single force/override path into a probed datapath
// signal; holds the forced value for a programmed length and checks the probe.
module override_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int LW   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_value,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]   req_ready,
    input  logic              abort,
    input  logic [W-1:0]      obs_value,
    output logic              force_en,
    output logic [W-1:0]      force_val,
    output logic [2:0]        active_id,
    output logic              done,
    output logic              mismatch,
    output logic [2:0]        mismatch_id,
    output logic [W-1:0]      mismatch_obs
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HOLD,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      rr_ptr;
    logic [LW-1:0]   counter;

    logic            found;
    logic [2:0]      grant_id;
    logic [W-1:0]    grant_value;
    logic [LW-1:0]   grant_len;

    // Two upward passes: indices at/above rr_ptr first, then the wrapped ones.
    always_comb begin : arbiter
        found       = 1'b0;
        grant_id    = '0;
        grant_value = '0;
        grant_len   = '0;
        req_ready   = '0;
        if (state == IDLE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i >= 32'(rr_ptr))) begin
                    found        = 1'b1;
                    req_ready[i] = 1'b1;
                    grant_id     = 3'(i);
                    grant_value  = req_value[i*W +: W];
                    grant_len    = req_len[i*LW +: LW];
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i]) begin
                    found        = 1'b1;
                    req_ready[i] = 1'b1;
                    grant_id     = 3'(i);
                    grant_value  = req_value[i*W +: W];
                    grant_len    = req_len[i*LW +: LW];
                end
            end
        end
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ARM;
            ARM:     state_next = (abort || counter == '0) ? RELEASE : HOLD;
            HOLD:    if (abort || counter == LW'(1)) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin : state_reg
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin : datapath
        if (!reset) begin
            rr_ptr       <= '0;
            counter      <= '0;
            force_en     <= 1'b0;
            force_val    <= '0;
            active_id    <= '0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_id  <= '0;
            mismatch_obs <= '0;
        end else begin
            force_en <= (state_next == ARM) || (state_next == HOLD);
            done     <= (state_next == RELEASE);
            case (state)
                IDLE: begin
                    if (found) begin
                        force_val <= grant_value;
                        counter   <= grant_len;
                        active_id <= grant_id;
                    end
                end
                HOLD: begin
                    counter <= counter - LW'(1);
                    // First failing owner/value wins; an abort cycle is not checked.
                    if (!abort && !mismatch && obs_value != force_val) begin
                        mismatch     <= 1'b1;
                        mismatch_id  <= active_id;
                        mismatch_obs <= obs_value;
                    end
                end
                RELEASE: begin
                    rr_ptr <= (active_id == 3'(NREQ-1)) ? '0 : active_id + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_override_scheduler.sv
// Randomized bench for override_scheduler (NREQ=4 and NREQ=3 instances) against
// a transaction-timeline reference model.
module tb_override_scheduler;

    localparam int W  = 16;
    localparam int LW = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            abort = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [4*W-1:0]  req_value = '0;
    logic [4*LW-1:0] req_len   = '0;
    logic [W-1:0]    obs4 = '0;
    logic [W-1:0]    obs3 = '0;

    logic [3:0]   ready4;
    logic [2:0]   ready3;
    logic         fen4, fen3, done4, done3, mm4, mm3;
    logic [W-1:0] fval4, fval3, mmobs4, mmobs3;
    logic [2:0]   aid4, aid3, mmid4, mmid3;

    override_scheduler #(.NREQ(4), .W(W), .LW(LW)) u4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_value(req_value), .req_len(req_len),
        .req_ready(ready4), .abort(abort), .obs_value(obs4),
        .force_en(fen4), .force_val(fval4), .active_id(aid4), .done(done4),
        .mismatch(mm4), .mismatch_id(mmid4), .mismatch_obs(mmobs4)
    );

    override_scheduler #(.NREQ(3), .W(W), .LW(LW)) u3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[2:0]), .req_value(req_value[3*W-1:0]), .req_len(req_len[3*LW-1:0]),
        .req_ready(ready3), .abort(abort), .obs_value(obs3),
        .force_en(fen3), .force_val(fval3), .active_id(aid3), .done(done3),
        .mismatch(mm3), .mismatch_id(mmid3), .mismatch_obs(mmobs3)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an override is a window that opens at the accept edge and
    // closes 1+len edges later (or at an abort edge); edges 2..1+len are compared.
    bit        m_busy[2];
    bit        m_gap[2];
    bit        m_done[2];
    bit        m_mm[2];
    int        m_rr[2];
    int        m_id[2];
    int        m_len[2];
    int        m_t[2];
    int        m_mmid[2];
    bit [15:0] m_val[2];
    bit [15:0] m_mmobs[2];
    int        cyc = 0;
    bit        obs_follow = 1'b1;

    int fen_cnt  = 0;
    int done_cnt = 0;
    int log4[$];
    int log3[$];
    bit prev4 = 1'b0;
    bit prev3 = 1'b0;

    function automatic int pick(input logic [3:0] v, input int rr, input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (rr + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int d);
        int g;
        logic [3:0] r;
        r = '0;
        g = pick(req_valid, m_rr[d], (d == 0) ? 4 : 3);
        if (!m_busy[d] && !m_gap[d] && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n, el, g;
            logic [15:0] o;
            n = (d == 0) ? 4 : 3;
            o = (d == 0) ? obs4 : obs3;
            m_done[d] = 1'b0;
            if (!reset) begin
                m_busy[d] = 0; m_gap[d] = 0; m_rr[d] = 0; m_id[d] = 0; m_len[d] = 0;
                m_val[d] = '0; m_mm[d] = 0; m_mmid[d] = 0; m_mmobs[d] = '0;
            end else if (m_busy[d]) begin
                el = cyc - m_t[d];
                if (!abort && el >= 2 && o != m_val[d] && !m_mm[d]) begin
                    m_mm[d] = 1; m_mmid[d] = m_id[d]; m_mmobs[d] = o;
                end
                if (abort || el == 1 + m_len[d]) begin
                    m_busy[d] = 0; m_done[d] = 1; m_gap[d] = 1;
                    m_rr[d] = (m_id[d] + 1) % n;
                end
            end else if (m_gap[d]) begin
                m_gap[d] = 0;
            end else begin
                g = pick(req_valid, m_rr[d], n);
                if (g >= 0) begin
                    m_busy[d] = 1; m_t[d] = cyc; m_id[d] = g;
                    m_val[d] = req_value[g*W +: W];
                    m_len[d] = int'(req_len[g*LW +: LW]);
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("ready4", 32'(ready4), 32'(exp_ready(0)));
        check("ready3", 32'(ready3), 32'(exp_ready(1)));
        check("force_en4", 32'(fen4), 32'(m_busy[0]));
        check("force_en3", 32'(fen3), 32'(m_busy[1]));
        check("force_val4", 32'(fval4), 32'(m_val[0]));
        check("force_val3", 32'(fval3), 32'(m_val[1]));
        check("active_id4", 32'(aid4), m_id[0]);
        check("active_id3", 32'(aid3), m_id[1]);
        check("done4", 32'(done4), 32'(m_done[0]));
        check("done3", 32'(done3), 32'(m_done[1]));
        check("mismatch4", 32'(mm4), 32'(m_mm[0]));
        check("mismatch3", 32'(mm3), 32'(m_mm[1]));
        check("mismatch_id4", 32'(mmid4), m_mmid[0]);
        check("mismatch_id3", 32'(mmid3), m_mmid[1]);
        check("mismatch_obs4", 32'(mmobs4), 32'(m_mmobs[0]));
        check("mismatch_obs3", 32'(mmobs3), 32'(m_mmobs[1]));
        if (fen4 === 1'b1) fen_cnt++;
        if (done4 === 1'b1) done_cnt++;
        if (fen4 === 1'b1 && !prev4) log4.push_back(int'(aid4));
        if (fen3 === 1'b1 && !prev3) log3.push_back(int'(aid3));
        prev4 = (fen4 === 1'b1);
        prev3 = (fen3 === 1'b1);
    endtask

    task automatic cycle();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        if (obs_follow) begin
            obs4 = m_val[0];
            obs3 = m_val[1];
        end
    endtask

    task automatic clr();
        fen_cnt = 0;
        done_cnt = 0;
        log4.delete();
        log3.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic idle_wait();
        for (int k = 0; k < 80 && (m_busy[0] || m_gap[0] || m_busy[1] || m_gap[1]); k++) cycle();
        cycle();
    endtask

    task automatic grab(input int r, input logic [15:0] val, input int len);
        req_value[r*W +: W]   = val;
        req_len[r*LW +: LW]   = 5'(len);
        req_valid             = '0;
        req_valid[r]          = 1'b1;
        for (int k = 0; k < 40 && !m_busy[0]; k++) cycle();
        check("grant_seen", 32'(fen4), 32'd1);
        req_valid = '0;
    endtask

    initial begin
        int rr_seq4[4];
        int rr_seq3[3];
        rr_seq4 = '{0, 1, 3, 0};
        rr_seq3 = '{0, 1, 0};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        cycle();

        // single requester, obs follows force_val
        clr();
        grab(0, 16'hDEAD, 3);
        repeat (6) cycle();
        check("t1_fen_cycles", fen_cnt, 4);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_force_val", 32'(fval4), 32'hDEAD);
        check("t1_active_id", 32'(aid4), 0);
        check("t1_mismatch", 32'(mm4), 0);

        // round robin over 0,1,3 (NREQ=3 copy wraps from rr_ptr=2 to 0)
        do_reset();
        clr();
        req_len   = {5'd1, 5'd1, 5'd1, 5'd1};
        req_value = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        req_valid = 4'b1011;
        for (int k = 0; k < 60 && log4.size() < 4; k++) cycle();
        req_valid = '0;
        for (int i = 0; i < 4; i++) check("rr_order4", (i < log4.size()) ? log4[i] : 99, rr_seq4[i]);
        for (int i = 0; i < 3; i++) check("rr_order3", (i < log3.size()) ? log3[i] : 99, rr_seq3[i]);
        idle_wait();

        // first mismatch captured, later ones and the ARM cycle ignored
        do_reset();
        obs_follow = 1'b0;
        obs4 = 16'hBEEF;
        obs3 = 16'hBEEF;
        grab(2, 16'hBEEF, 4);
        obs4 = 16'h0000; obs3 = 16'h0000; cycle();
        obs4 = 16'hBEEF; obs3 = 16'hBEEF; cycle();
        obs4 = 16'h1234; obs3 = 16'h1234; cycle();
        obs4 = 16'h5555; obs3 = 16'h5555; cycle();
        obs4 = 16'hBEEF; obs3 = 16'hBEEF; cycle();
        cycle();
        obs_follow = 1'b1;
        check("t3_mismatch", 32'(mm4), 1);
        check("t3_mismatch_id", 32'(mmid4), 2);
        check("t3_mismatch_obs", 32'(mmobs4), 32'h1234);
        check("t3_mismatch_obs3", 32'(mmobs3), 32'h1234);
        idle_wait();

        // len=0, then abort in the first HOLD cycle
        do_reset();
        clr();
        grab(0, 16'h0A0A, 0);
        repeat (4) cycle();
        check("len0_fen_cycles", fen_cnt, 1);
        check("len0_done_pulses", done_cnt, 1);
        check("len0_mismatch", 32'(mm4), 0);
        clr();
        grab(1, 16'h1111, 10);
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (4) cycle();
        check("abort_fen_cycles", fen_cnt, 2);
        check("abort_done_pulses", done_cnt, 1);

        // reset in the second HOLD cycle, then a fresh arbitration from 0
        grab(2, 16'h2222, 10);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("rst_fen", 32'(fen4), 0);
        check("rst_force_val", 32'(fval4), 0);
        clr();
        req_valid = 4'b1111;
        for (int k = 0; k < 20 && log4.size() == 0; k++) cycle();
        req_valid = '0;
        check("rst_first_grant", (log4.size() > 0) ? log4[0] : 99, 0);
        check("rst_no_done", done_cnt, 0);
        idle_wait();

        // maximum hold length
        clr();
        grab(3, 16'h3131, 31);
        repeat (36) cycle();
        check("len31_fen_cycles", fen_cnt, 32);
        check("len31_done_pulses", done_cnt, 1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_value[i*W +: W] = 16'($urandom);
                    req_len[i*LW +: LW] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
                end
            end
            abort = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) != 0);
            cycle();
            if ($urandom_range(0, 24) == 0) obs4 = obs4 ^ 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) obs3 = obs3 ^ 16'(1 << $urandom_range(0, 15));
        end
        abort = 1'b0;
        reset = 1'b1;
        req_valid = '0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
